// File: rtl/regs_wb_arbiter_if.sv
// Writeback request/response bundle between the three writeback sources
// and the register file write-port arbiter.
interface regs_wb_arbiter_if #(
  parameter int RegAddrBus = 5,
  parameter int RegBus     = 32
);
  logic                  ex_valid_i;
  logic [RegAddrBus-1:0] ex_waddr_i;
  logic [RegBus-1:0]     ex_wdata_i;
  logic                  ex_ready_o;

  logic                  lsu_valid_i;
  logic [RegAddrBus-1:0] lsu_waddr_i;
  logic [RegBus-1:0]     lsu_wdata_i;
  logic                  lsu_ready_o;

  logic                  dbg_valid_i;
  logic [RegAddrBus-1:0] dbg_waddr_i;
  logic [RegBus-1:0]     dbg_wdata_i;
  logic                  dbg_ready_o;

  logic                  we_o;
  logic [RegAddrBus-1:0] waddr_o;
  logic [RegBus-1:0]     wdata_o;
  logic [2:0]            grant_o;

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output dbg_valid_i, dbg_waddr_i, dbg_wdata_i,
    input  ex_ready_o, lsu_ready_o, dbg_ready_o,
    input  we_o, waddr_o, wdata_o, grant_o
  );

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  dbg_valid_i, dbg_waddr_i, dbg_wdata_i,
    output ex_ready_o, lsu_ready_o, dbg_ready_o,
    output we_o, waddr_o, wdata_o, grant_o
  );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Register file write-port arbiter for ex / lsu / dbg writeback.
// Starved lsu/dbg pre-empts ex, otherwise ex wins, then lsu/dbg share by
// round-robin. The winning write is registered once onto the write port.
// Writes to x0 consume a grant but never raise we_o.
module regs_wb_arbiter #(
  parameter int RegAddrBus   = 5,
  parameter int RegBus       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  regs_wb_arbiter_if.slave bus
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);
  localparam logic [3:0] ScMax       = 4'd15;

  // rp_q: 0 = lsu preferred, 1 = dbg preferred
  logic                  rp_q, rp_d;
  logic [3:0]            sc_lsu_q, sc_lsu_d;
  logic [3:0]            sc_dbg_q, sc_dbg_d;
  logic [2:0]            gnt;
  logic                  lsu_starved, dbg_starved;
  logic [RegAddrBus-1:0] win_waddr;
  logic [RegBus-1:0]     win_wdata;

  logic                  we_q;
  logic [RegAddrBus-1:0] waddr_q;
  logic [RegBus-1:0]     wdata_q;
  logic [2:0]            grant_q;

  assign lsu_starved = bus.lsu_valid_i && (sc_lsu_q >= StarveLimit);
  assign dbg_starved = bus.dbg_valid_i && (sc_dbg_q >= StarveLimit);

  // Winner selection; nothing is accepted while reset is asserted
  always_comb begin
    gnt = 3'b000;
    if (!rst_i) begin
      if (lsu_starved && dbg_starved) begin
        gnt = rp_q ? 3'b100 : 3'b010;
      end else if (lsu_starved) begin
        gnt = 3'b010;
      end else if (dbg_starved) begin
        gnt = 3'b100;
      end else if (bus.ex_valid_i) begin
        gnt = 3'b001;
      end else if (bus.lsu_valid_i && bus.dbg_valid_i) begin
        gnt = rp_q ? 3'b100 : 3'b010;
      end else if (bus.lsu_valid_i) begin
        gnt = 3'b010;
      end else if (bus.dbg_valid_i) begin
        gnt = 3'b100;
      end
    end
  end

  assign bus.ex_ready_o  = gnt[0];
  assign bus.lsu_ready_o = gnt[1];
  assign bus.dbg_ready_o = gnt[2];

  // Winner payload mux
  always_comb begin
    win_waddr = bus.ex_waddr_i;
    win_wdata = bus.ex_wdata_i;
    if (gnt[1]) begin
      win_waddr = bus.lsu_waddr_i;
      win_wdata = bus.lsu_wdata_i;
    end else if (gnt[2]) begin
      win_waddr = bus.dbg_waddr_i;
      win_wdata = bus.dbg_wdata_i;
    end
  end

  // Round-robin pointer and starvation counter next state
  always_comb begin
    rp_d = rp_q;
    if (gnt[1]) begin
      rp_d = 1'b1;
    end else if (gnt[2]) begin
      rp_d = 1'b0;
    end

    sc_lsu_d = sc_lsu_q;
    if (!bus.lsu_valid_i || gnt[1]) begin
      sc_lsu_d = 4'd0;
    end else if (sc_lsu_q != ScMax) begin
      sc_lsu_d = sc_lsu_q + 4'd1;
    end

    sc_dbg_d = sc_dbg_q;
    if (!bus.dbg_valid_i || gnt[2]) begin
      sc_dbg_d = 4'd0;
    end else if (sc_dbg_q != ScMax) begin
      sc_dbg_d = sc_dbg_q + 4'd1;
    end
  end

  // Arbitration state and registered write port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rp_q     <= 1'b0;
      sc_lsu_q <= 4'd0;
      sc_dbg_q <= 4'd0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      grant_q  <= 3'b000;
    end else begin
      rp_q     <= rp_d;
      sc_lsu_q <= sc_lsu_d;
      sc_dbg_q <= sc_dbg_d;
      we_q     <= (|gnt) && (win_waddr != '0);
      grant_q  <= gnt;
      if (|gnt) begin
        waddr_q <= win_waddr;
        wdata_q <= win_wdata;
      end
    end
  end

  assign bus.we_o    = we_q;
  assign bus.waddr_o = waddr_q;
  assign bus.wdata_o = wdata_q;
  assign bus.grant_o = grant_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter: directed scenarios followed by random traffic,
// each cycle compared against a rule-level model of the arbiter.
module tb_regs_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regs_wb_arbiter_if #(.RegAddrBus(AW), .RegBus(DW)) bus ();

  regs_wb_arbiter #(
    .RegAddrBus  (AW),
    .RegBus      (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // stimulus: index 0 = ex, 1 = lsu, 2 = dbg
  logic          tv [3];
  logic [AW-1:0] ta [3];
  logic [DW-1:0] td [3];
  logic          trst;

  // model state
  int            m_rp;
  int            m_sc [3];
  logic          e_we;
  logic [2:0]    e_grant;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;

  int n_pass  = 0;
  int n_total = 0;
  int last_w  = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive();
    rst             = trst;
    bus.ex_valid_i  = tv[0];
    bus.ex_waddr_i  = ta[0];
    bus.ex_wdata_i  = td[0];
    bus.lsu_valid_i = tv[1];
    bus.lsu_waddr_i = ta[1];
    bus.lsu_wdata_i = td[1];
    bus.dbg_valid_i = tv[2];
    bus.dbg_waddr_i = ta[2];
    bus.dbg_wdata_i = td[2];
  endtask

  // Rule-level winner: starved sources in rotation order, then ex, then
  // any valid source in rotation order.
  function automatic int pick();
    int order [2];
    if (trst) return -1;
    order[0] = (m_rp == 1) ? 2 : 1;
    order[1] = (m_rp == 1) ? 1 : 2;
    foreach (order[k]) if (tv[order[k]] && m_sc[order[k]] >= SL) return order[k];
    if (tv[0]) return 0;
    foreach (order[k]) if (tv[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic cycle();
    int w;
    logic [2:0] rdy;
    drive();
    #1;
    w   = pick();
    rdy = {bus.dbg_ready_o, bus.lsu_ready_o, bus.ex_ready_o};
    chk("ready", 32'(rdy), (w < 0) ? 32'd0 : (32'd1 << w));
    if (trst) begin
      m_rp    = 0;
      m_sc    = '{0, 0, 0};
      e_we    = 1'b0;
      e_grant = 3'b000;
      e_waddr = '0;
      e_wdata = '0;
    end else begin
      for (int s = 1; s <= 2; s++) begin
        if (!tv[s] || w == s) m_sc[s] = 0;
        else if (m_sc[s] < 15) m_sc[s] = m_sc[s] + 1;
      end
      if (w == 1) m_rp = 1;
      else if (w == 2) m_rp = 0;
      if (w >= 0) begin
        e_we    = (ta[w] != 0);
        e_grant = 3'(1 << w);
        e_waddr = ta[w];
        e_wdata = td[w];
      end else begin
        e_we    = 1'b0;
        e_grant = 3'b000;
      end
    end
    @(posedge clk);
    #1;
    chk("we", 32'(bus.we_o), 32'(e_we));
    chk("grant", 32'(bus.grant_o), 32'(e_grant));
    chk("waddr", 32'(bus.waddr_o), 32'(e_waddr));
    chk("wdata", bus.wdata_o, e_wdata);
    last_w = w;
  endtask

  task automatic idle_all();
    for (int s = 0; s < 3; s++) tv[s] = 1'b0;
  endtask

  initial begin
    m_rp    = 0;
    m_sc    = '{0, 0, 0};
    e_we    = 1'b0;
    e_grant = 3'b000;
    e_waddr = '0;
    e_wdata = '0;
    for (int s = 0; s < 3; s++) begin
      tv[s] = 1'b1;
      ta[s] = AW'(s + 1);
      td[s] = 32'h100 + 32'(s);
    end

    // reset held two cycles with every source requesting
    trst = 1'b1;
    cycle();
    chk("rst_we", 32'(bus.we_o), 32'd0);
    cycle();
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    trst = 1'b0;
    cycle();
    chk("post_rst_ex_first", 32'(last_w), 32'd0);
    idle_all();
    cycle();

    // single ex write
    tv[0] = 1'b1; ta[0] = 5'd5; td[0] = 32'hDEADBEEF;
    cycle();
    chk("ex_we", 32'(bus.we_o), 32'd1);
    chk("ex_waddr", 32'(bus.waddr_o), 32'd5);
    chk("ex_wdata", bus.wdata_o, 32'hDEADBEEF);
    chk("ex_grant", 32'(bus.grant_o), 32'b001);
    tv[0] = 1'b0;
    cycle();
    chk("ex_idle_we", 32'(bus.we_o), 32'd0);

    // round-robin between lsu and dbg from a fresh reset
    trst = 1'b1;
    cycle();
    trst = 1'b0;
    tv[1] = 1'b1; ta[1] = 5'd7;  td[1] = 32'hA5A5_0001;
    tv[2] = 1'b1; ta[2] = 5'd9;  td[2] = 32'h5A5A_0002;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_order", 32'(last_w), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    idle_all();
    cycle();

    // ex and lsu both continuous: lsu breaks through every fifth cycle
    tv[0] = 1'b1; ta[0] = 5'd3;
    tv[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("starve_order", 32'(last_w), (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    idle_all();
    cycle();

    // point rp at dbg, then a dbg write to x0 must still move rp back to lsu
    tv[1] = 1'b1;
    cycle();
    tv[1] = 1'b0;
    tv[2] = 1'b1; ta[2] = 5'd0; td[2] = 32'h1234;
    cycle();
    chk("x0_accept", 32'(last_w), 32'd2);
    chk("x0_we", 32'(bus.we_o), 32'd0);
    chk("x0_grant", 32'(bus.grant_o), 32'b100);
    tv[1] = 1'b1; ta[2] = 5'd11;
    cycle();
    chk("x0_rp_lsu_next", 32'(last_w), 32'd1);
    idle_all();
    cycle();

    // reset mid-stream while lsu has been refused three times
    tv[0] = 1'b1; tv[1] = 1'b1;
    repeat (3) cycle();
    trst = 1'b1;
    cycle();
    chk("mid_rst_we", 32'(bus.we_o), 32'd0);
    chk("mid_rst_grant", 32'(bus.grant_o), 32'd0);
    trst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("mid_rst_order", 32'(last_w), (i == 4) ? 32'd1 : 32'd0);
    end
    idle_all();
    cycle();

    // random traffic; sources hold each request until it is accepted
    for (int i = 0; i < 600; i++) begin
      for (int s = 0; s < 3; s++) begin
        if (!tv[s] && $urandom_range(0, 99) < ((s == 0) ? 85 : 50)) begin
          tv[s] = 1'b1;
          ta[s] = ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
          td[s] = $urandom;
        end
      end
      trst = ($urandom_range(0, 39) == 0);
      cycle();
      if (last_w >= 0) tv[last_w] = 1'b0;
    end
    trst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
